icache_refill: RTL and testbench

ICACHE_REFILL -- requirements
Module: icache_refill

---
 rtl/icache_refill.sv | 97 +++++++++
 tb/tb_icache_refill.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill.sv
// Instruction-cache line refill: one word per miss; fetch follows mem_rvalid by one cycle (min 4 cycles miss-to-fetch).
// Stalls in REQ until mem_gnt; a silent memory is retried after TIMEOUT WAIT cycles and flagged in refill_err.
module icache_refill #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cache_miss,
    input  logic [19:0] miss_addr,
    output logic        mem_req,
    output logic [19:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        fetch,
    output logic [31:0] write_data,
    output logic        refill_busy,
    input  logic        err_clr,
    output logic        refill_err,
    output logic [15:0] miss_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_FILL
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic       timeout;
    logic       unused_addr_lsb;

    assign unused_addr_lsb = ^miss_addr[1:0];

    always_comb begin
        state_nxt = state;
        timeout   = 1'b0;
        case (state)
            S_IDLE: if (cache_miss) state_nxt = S_REQ;
            S_REQ:  if (mem_gnt) state_nxt = S_WAIT;
            S_WAIT: begin
                if (mem_rvalid) begin
                    state_nxt = S_FILL;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = S_REQ;
                    timeout   = 1'b1;
                end
            end
            S_FILL:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            mem_addr   <= '0;
            write_data <= '0;
            wait_cnt   <= '0;
            refill_err <= 1'b0;
            miss_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && cache_miss) begin
                mem_addr <= {miss_addr[19:2], 2'b00};
            end
            // Held at zero outside WAIT so every entry (including retries) starts from 0.
            if (state != S_WAIT) begin
                wait_cnt <= '0;
            end else if (!mem_rvalid) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (state == S_WAIT && mem_rvalid) begin
                write_data <= mem_rdata;
            end
            if (timeout) begin
                refill_err <= 1'b1;
            end else if (err_clr) begin
                refill_err <= 1'b0;
            end
            if (state == S_FILL && miss_count != 16'hFFFF) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end

    // Decoded from state so that RST removes them without a clock edge.
    assign mem_req     = (state == S_REQ);
    assign fetch       = (state == S_FILL);
    assign refill_busy = (state != S_IDLE);

endmodule

// File: tb/tb_icache_refill.sv
// Self-checking bench for icache_refill: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model of the refill.
module tb_icache_refill;

    localparam int TO = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        cache_miss;
    logic [19:0] miss_addr;
    logic        mem_req;
    logic [19:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        fetch;
    logic [31:0] write_data;
    logic        refill_busy;
    logic        err_clr;
    logic        refill_err;
    logic [15:0] miss_count;

    always #5 CLK = ~CLK;

    icache_refill #(.TIMEOUT(TO)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .cache_miss  (cache_miss),
        .miss_addr   (miss_addr),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .fetch       (fetch),
        .write_data  (write_data),
        .refill_busy (refill_busy),
        .err_clr     (err_clr),
        .refill_err  (refill_err),
        .miss_count  (miss_count)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    bit load_cnt = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a miss makes the block busy; it then needs a grant, then data (or
    // gives up after TO silent cycles and asks again), then one fill cycle.
    bit          m_busy, m_granted, m_fill, m_err, m_tmo;
    int          m_waited;
    int          m_count;
    logic [19:0] m_addr;
    logic [31:0] m_wdata;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_busy = 0; m_granted = 0; m_fill = 0; m_err = 0;
            m_waited = 0; m_count = 0; m_addr = '0; m_wdata = '0;
        end else if (load_cnt) begin
            m_count = 16'hFFFC;
        end else begin
            m_tmo = 0;
            if (m_fill) begin
                m_fill = 0;
                m_busy = 0;
                if (m_count < 65535) m_count++;
            end else if (!m_busy) begin
                if (cache_miss) begin
                    m_busy    = 1;
                    m_granted = 0;
                    m_addr    = miss_addr & 20'hFFFFC;
                end
            end else if (!m_granted) begin
                if (mem_gnt) begin
                    m_granted = 1;
                    m_waited  = 0;
                end
            end else if (mem_rvalid) begin
                m_wdata   = mem_rdata;
                m_fill    = 1;
                m_granted = 0;
            end else if (m_waited == TO - 1) begin
                m_granted = 0;
                m_tmo     = 1;
            end else begin
                m_waited++;
            end
            if (m_tmo) m_err = 1;
            else if (err_clr) m_err = 0;
        end
    end

    always @(negedge CLK) begin
        if (chk_en && !RST) begin
            chk("mem_req",     32'(mem_req),     32'(m_busy && !m_granted && !m_fill));
            chk("fetch",       32'(fetch),       32'(m_fill));
            chk("refill_busy", 32'(refill_busy), 32'(m_busy));
            chk("refill_err",  32'(refill_err),  32'(m_err));
            chk("write_data",  write_data,       m_wdata);
            chk("miss_count",  32'(miss_count),  32'(m_count));
            if (m_busy) chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        end
    end

    task automatic step(input logic miss, input logic [19:0] a, input logic gnt,
                        input logic rv, input logic [31:0] rd, input logic clr);
        cache_miss = miss;
        miss_addr  = a;
        mem_gnt    = gnt;
        mem_rvalid = rv;
        mem_rdata  = rd;
        err_clr    = clr;
        @(posedge CLK);
        #2;
    endtask

    task automatic idle();
        step(1'b0, 20'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    int nreq, nfetch;

    initial begin
        RST = 1'b1;
        cache_miss = 0; miss_addr = '0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; err_clr = 0;
        repeat (3) @(posedge CLK);
        #2;
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_busy", 32'(refill_busy), 0);
        chk("rst_fetch", 32'(fetch), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wdata", write_data, 0);
        chk("rst_count", 32'(miss_count), 0);
        RST = 1'b0;
        chk_en = 1'b1;

        // Basic refill: fetch in the fourth cycle counting the miss cycle.
        step(1, 20'h00127, 0, 0, 0, 0);
        chk("basic_req", 32'(mem_req), 1);
        chk("basic_addr", 32'(mem_addr), 32'h00124);
        step(0, 0, 1, 0, 0, 0);
        chk("basic_req_drop", 32'(mem_req), 0);
        step(0, 0, 0, 1, 32'h00B70000, 0);
        chk("basic_fetch", 32'(fetch), 1);
        chk("basic_wdata", write_data, 32'h00B70000);
        idle();
        chk("basic_fetch_end", 32'(fetch), 0);
        chk("basic_count", 32'(miss_count), 1);

        // Grant withheld for 5 cycles.
        nreq = 0; nfetch = 0;
        step(1, 20'hABCDE, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            if (mem_req) nreq++;
            if (fetch) nfetch++;
            if (mem_req) chk("stall_addr", 32'(mem_addr), 32'h000ABCDC);
            step(0, 20'h55555, 1'(i == 5), 1'(i == 6), 32'hCAFE0000 + 32'(i), 0);
        end
        if (fetch) nfetch++;
        chk("stall_req_cycles", 32'(nreq), 6);
        chk("stall_fetch_pulses", 32'(nfetch), 1);
        chk("stall_wdata", write_data, 32'hCAFE0006);

        // Timeout after TO silent WAIT cycles, retry, then clear.
        step(1, 20'h00040, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < TO - 1; i++) begin
            idle();
            chk("to_waiting", 32'(mem_req), 0);
            chk("to_no_err_yet", 32'(refill_err), 0);
        end
        idle();
        chk("to_retry_req", 32'(mem_req), 1);
        chk("to_err_set", 32'(refill_err), 1);
        chk("to_retry_addr", 32'(mem_addr), 32'h00040);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 32'h1234ABCD, 0);
        chk("to_fetch", 32'(fetch), 1);
        idle();
        chk("to_err_sticky", 32'(refill_err), 1);
        step(0, 0, 0, 0, 0, 1);
        chk("to_err_clr", 32'(refill_err), 0);

        // Spurious rvalid in IDLE/REQ and gnt in WAIT.
        step(0, 0, 0, 1, 32'h0000DEAD, 0);
        chk("sp_idle_busy", 32'(refill_busy), 0);
        chk("sp_idle_wdata", write_data, 32'h1234ABCD);
        step(1, 20'h00300, 0, 1, 32'h0000BEEF, 0);
        chk("sp_to_req", 32'(mem_req), 1);
        step(0, 0, 0, 1, 32'h0000BEEF, 0);
        chk("sp_req_hold", 32'(mem_req), 1);
        chk("sp_req_fetch", 32'(fetch), 0);
        chk("sp_req_wdata", write_data, 32'h1234ABCD);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("sp_wait_req", 32'(mem_req), 0);
        chk("sp_wait_busy", 32'(refill_busy), 1);
        chk("sp_wait_fetch", 32'(fetch), 0);
        step(0, 0, 0, 1, 32'h0BADF00D, 0);
        idle();

        // Reset pulsed between edges while in WAIT.
        step(1, 20'h00804, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        #1 RST = 1'b1;
        #1;
        chk("rr_req", 32'(mem_req), 0);
        chk("rr_busy", 32'(refill_busy), 0);
        chk("rr_fetch", 32'(fetch), 0);
        chk("rr_addr", 32'(mem_addr), 0);
        chk("rr_wdata", write_data, 0);
        chk("rr_err", 32'(refill_err), 0);
        chk("rr_count", 32'(miss_count), 0);
        RST = 1'b0;
        step(0, 0, 0, 1, 32'hFFFF0000, 0);
        chk("rr_late_rvalid_fetch", 32'(fetch), 0);
        chk("rr_late_rvalid_wdata", write_data, 0);
        idle();
        chk("rr_no_fetch", 32'(fetch), 0);
        step(1, 20'h00777, 0, 0, 0, 0);
        chk("rr_new_req", 32'(mem_req), 1);
        chk("rr_new_addr", 32'(mem_addr), 32'h00774);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 32'h00000001, 0);
        idle();

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            step(1'($urandom_range(0, 1)), 20'($urandom), 1'($urandom_range(0, 9) < 4),
                 1'($urandom_range(0, 9) < 3), $urandom, 1'($urandom_range(0, 9) == 0));
        end

        // Drain, then preload the counter instead of running 65536 refills.
        repeat (6) step(0, 0, 1, 1, 32'h0, 0);
        chk("drain_idle", 32'(refill_busy), 0);
        chk_en = 1'b0;
        load_cnt = 1'b1;
        force dut.miss_count = 16'hFFFC;
        idle();
        release dut.miss_count;
        load_cnt = 1'b0;
        chk_en = 1'b1;
        chk("sat_preload", 32'(miss_count), 32'hFFFC);
        for (int k = 0; k < 5; k++) begin
            step(1, 20'h00010 + 20'(k * 4), 0, 0, 0, 0);
            step(0, 0, 1, 0, 0, 0);
            step(0, 0, 0, 1, 32'h5A000000 + 32'(k), 0);
            idle();
            chk("sat_count", 32'(miss_count), (k < 3) ? 32'hFFFD + 32'(k) : 32'hFFFF);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
